// File: rtl/web_resource_ctrl_if.sv
// Command/fire handshake and resource status bundle between the web command
// source (master) and web_resource_ctrl (slave).
interface web_resource_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] func_sel;
   logic [3:0] target_sel;
   logic       fire_valid;
   logic [2:0] fire_func;
   logic [3:0] fire_target;
   logic       cmd_reject;
   logic [5:0] tracer_count;
   logic [7:0] fluid_level;
   logic [7:0] energy_level;
   logic       fluid_empty;
   logic       energy_empty;
   logic       busy;

   modport slave (
      input  cmd_valid, func_sel, target_sel,
      output cmd_ready, fire_valid, fire_func, fire_target, cmd_reject,
             tracer_count, fluid_level, energy_level, fluid_empty, energy_empty, busy
   );

   modport master (
      output cmd_valid, func_sel, target_sel,
      input  cmd_ready, fire_valid, fire_func, fire_target, cmd_reject,
             tracer_count, fluid_level, energy_level, fluid_empty, energy_empty, busy
   );
endinterface

// File: rtl/web_resource_ctrl.sv
// Web command front-end: budgets fluid/tracer/energy, strobes the WebShooter
// core on fire commands and sequences reloads.
//
// state    | meaning
// IDLE     | ready to accept a command
// COOLDOWN | post-fire hold-off, cmd_ready low
// RELOAD   | reload in progress, level restored on final cycle
// DEAD     | energy exhausted, locked until reset
module web_resource_ctrl #(
   parameter int FLUID_MAX       = 64,
   parameter int TRACER_MAX      = 8,
   parameter int ENERGY_MAX      = 32,
   parameter int COOLDOWN_CYCLES = 2,
   parameter int RELOAD_CYCLES   = 4
) (
   input logic          clk,
   input logic          reset,
   web_resource_ctrl_if.slave cmd
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_COOLDOWN = 2'd1;
   localparam logic [1:0] ST_RELOAD   = 2'd2;
   localparam logic [1:0] ST_DEAD     = 2'd3;

   localparam int TMR_MAX = (COOLDOWN_CYCLES > RELOAD_CYCLES) ? COOLDOWN_CYCLES : RELOAD_CYCLES;
   localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [7:0]    FLUID_FULL  = 8'(FLUID_MAX);
   localparam logic [5:0]    TRACER_FULL = 6'(TRACER_MAX);
   localparam logic [7:0]    ENERGY_FULL = 8'(ENERGY_MAX);
   localparam logic [TW-1:0] TMR_COOL    = TW'(COOLDOWN_CYCLES - 1);
   localparam logic [TW-1:0] TMR_RELOAD  = TW'(RELOAD_CYCLES - 1);

   logic [1:0]    state;
   logic [TW-1:0] tmr;
   logic          reload_tracer;
   logic [7:0]    fluid;
   logic [5:0]    tracer;
   logic [7:0]    energy;
   logic          fire_valid;
   logic [2:0]    fire_func;
   logic [3:0]    fire_target;
   logic          cmd_reject;

   logic [7:0] cost_fluid;
   logic [5:0] cost_tracer;
   logic [7:0] cost_energy;
   logic       is_reload;
   logic       is_fire;
   logic       refuse;
   logic       accept;

   always_comb begin
      cost_fluid  = 8'd0;
      cost_tracer = 6'd0;
      cost_energy = 8'd0;
      case (cmd.func_sel)
         3'b001: begin cost_fluid = 8'd4;  cost_energy = 8'd1; end
         3'b010: begin cost_fluid = 8'd8;  cost_energy = 8'd2; end
         3'b011: begin cost_tracer = 6'd1; cost_energy = 8'd3; end
         3'b100: begin cost_fluid = 8'd16; cost_energy = 8'd4; end
         3'b101,
         3'b110: cost_energy = 8'd2;
         3'b111: cost_energy = 8'd1;
         default: ;
      endcase
   end

   assign is_reload = (cmd.func_sel == 3'b101) || (cmd.func_sel == 3'b110);
   assign is_fire   = (cmd.func_sel != 3'b000) && !is_reload;
   // A reload into an already-full store is treated as an unaffordable command
   assign refuse    = (fluid < cost_fluid) || (tracer < cost_tracer) || (energy < cost_energy)
                    || ((cmd.func_sel == 3'b101) && (fluid == FLUID_FULL))
                    || ((cmd.func_sel == 3'b110) && (tracer == TRACER_FULL));
   assign accept    = cmd.cmd_valid && cmd.cmd_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         tmr           <= '0;
         reload_tracer <= 1'b0;
         fluid         <= FLUID_FULL;
         tracer        <= TRACER_FULL;
         energy        <= ENERGY_FULL;
         fire_valid    <= 1'b0;
         fire_func     <= 3'd0;
         fire_target   <= 4'd0;
         cmd_reject    <= 1'b0;
      end else begin
         fire_valid <= 1'b0;
         cmd_reject <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (refuse) begin
                     cmd_reject <= 1'b1;
                  end else if (is_fire) begin
                     fluid       <= fluid - cost_fluid;
                     tracer      <= tracer - cost_tracer;
                     energy      <= energy - cost_energy;
                     fire_valid  <= 1'b1;
                     fire_func   <= cmd.func_sel;
                     fire_target <= cmd.target_sel;
                     tmr         <= TMR_COOL;
                     state       <= ST_COOLDOWN;
                  end else if (is_reload) begin
                     energy        <= energy - cost_energy;
                     reload_tracer <= (cmd.func_sel == 3'b110);
                     tmr           <= TMR_RELOAD;
                     state         <= ST_RELOAD;
                  end
               end
            end
            ST_COOLDOWN: begin
               if (tmr == '0) state <= (energy == 8'd0) ? ST_DEAD : ST_IDLE;
               else           tmr   <= tmr - 1'b1;
            end
            ST_RELOAD: begin
               if (tmr == '0) begin
                  if (reload_tracer) tracer <= TRACER_FULL;
                  else               fluid  <= FLUID_FULL;
                  state <= (energy == 8'd0) ? ST_DEAD : ST_IDLE;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign cmd.cmd_ready    = (state == ST_IDLE);
   assign cmd.busy         = (state == ST_COOLDOWN) || (state == ST_RELOAD);
   assign cmd.fire_valid   = fire_valid;
   assign cmd.fire_func    = fire_func;
   assign cmd.fire_target  = fire_target;
   assign cmd.cmd_reject   = cmd_reject;
   assign cmd.tracer_count = tracer;
   assign cmd.fluid_level  = fluid;
   assign cmd.energy_level = energy;
   assign cmd.fluid_empty  = (fluid == 8'd0);
   assign cmd.energy_empty = (energy == 8'd0);

endmodule

// File: tb/tb_web_resource_ctrl.sv
// Bench for web_resource_ctrl: directed scenarios plus random command traffic,
// all checked every cycle against a resource-budget model.
module tb_web_resource_ctrl;
   localparam int FLUID_MAX  = 64;
   localparam int TRACER_MAX = 8;
   localparam int ENERGY_MAX = 32;
   localparam int COOL       = 2;
   localparam int RLD        = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   web_resource_ctrl_if bus();

   web_resource_ctrl #(
      .FLUID_MAX(FLUID_MAX), .TRACER_MAX(TRACER_MAX), .ENERGY_MAX(ENERGY_MAX),
      .COOLDOWN_CYCLES(COOL), .RELOAD_CYCLES(RLD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cmd(bus)
   );

   always #5 clk = ~clk;

   // costs indexed by function code
   int cost_f[8] = '{0, 4, 8, 0, 16, 0, 0, 0};
   int cost_t[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
   int cost_e[8] = '{0, 1, 2, 3, 4, 2, 2, 1};

   int n_chk = 0;
   int n_err = 0;

   int m_fluid, m_tracer, m_energy, m_busy, m_pend, m_ffunc, m_ftgt;
   bit m_dead, m_fire, m_rej;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return !m_dead && (m_busy == 0);
   endfunction

   task automatic model_reset();
      m_fluid = FLUID_MAX; m_tracer = TRACER_MAX; m_energy = ENERGY_MAX;
      m_busy = 0; m_pend = 0; m_dead = 0; m_fire = 0; m_rej = 0;
      m_ffunc = 0; m_ftgt = 0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".ready"},  32'(bus.cmd_ready),    32'(m_ready()));
      chk({tag, ".busy"},   32'(bus.busy),         32'(m_busy > 0));
      chk({tag, ".fire"},   32'(bus.fire_valid),   32'(m_fire));
      chk({tag, ".reject"}, 32'(bus.cmd_reject),   32'(m_rej));
      chk({tag, ".ffunc"},  32'(bus.fire_func),    32'(m_ffunc));
      chk({tag, ".ftgt"},   32'(bus.fire_target),  32'(m_ftgt));
      chk({tag, ".fluid"},  32'(bus.fluid_level),  32'(m_fluid));
      chk({tag, ".tracer"}, 32'(bus.tracer_count), 32'(m_tracer));
      chk({tag, ".energy"}, 32'(bus.energy_level), 32'(m_energy));
      chk({tag, ".fempty"}, 32'(bus.fluid_empty),  32'(m_fluid == 0));
      chk({tag, ".eempty"}, 32'(bus.energy_empty), 32'(m_energy == 0));
   endtask

   // Drive one cycle of inputs, predict the next clock edge, then check.
   task automatic step(input bit v, input int f, input int t, input string tag);
      bit refuse;
      bit rdy;
      rdy = m_ready();
      bus.cmd_valid  = v;
      bus.func_sel   = 3'(f);
      bus.target_sel = 4'(t);
      m_fire = 0;
      m_rej  = 0;
      if (rdy && v) begin
         refuse = (m_fluid < cost_f[f]) || (m_tracer < cost_t[f]) || (m_energy < cost_e[f])
               || (f == 5 && m_fluid == FLUID_MAX) || (f == 6 && m_tracer == TRACER_MAX);
         if (refuse) m_rej = 1;
         else if (f != 0) begin
            m_fluid  -= cost_f[f];
            m_tracer -= cost_t[f];
            m_energy -= cost_e[f];
            if (f == 5 || f == 6) begin
               m_busy = RLD;
               m_pend = f;
            end else begin
               m_fire = 1; m_ffunc = f; m_ftgt = t;
               m_busy = COOL;
            end
         end
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            if (m_pend == 5) m_fluid = FLUID_MAX;
            if (m_pend == 6) m_tracer = TRACER_MAX;
            m_pend = 0;
            if (m_energy == 0) m_dead = 1;
         end
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!m_ready() && !m_dead && n < 50) begin
         step(0, 0, 0, tag);
         n++;
      end
      if (n >= 50) chk({tag, ".timeout"}, 32'(n), 32'(0));
   endtask

   task automatic send(input int f, input int t, input string tag);
      step(1, f, t, tag);
      wait_ready(tag);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      #1;
      model_reset();
      check_outputs(tag);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int lo;
      bus.cmd_valid = 1'b0;
      bus.func_sel = 3'd0;
      bus.target_sel = 4'd0;
      model_reset();
      repeat (2) @(negedge clk);

      // reset state
      apply_reset("rst");
      step(0, 0, 0, "rst_idle");
      chk("rst_tracer", 32'(bus.tracer_count), 32'd8);
      chk("rst_fluid",  32'(bus.fluid_level),  32'd64);
      chk("rst_energy", 32'(bus.energy_level), 32'd32);
      chk("rst_ready",  32'(bus.cmd_ready),    32'd1);

      // single web ball
      step(1, 2, 9, "ball");
      chk("ball_fire", 32'(bus.fire_valid),  32'd1);
      chk("ball_func", 32'(bus.fire_func),   32'd2);
      chk("ball_tgt",  32'(bus.fire_target), 32'd9);
      chk("ball_fluid", 32'(bus.fluid_level), 32'd56);
      chk("ball_energy", 32'(bus.energy_level), 32'd30);
      lo = 0;
      while (!bus.cmd_ready && lo < 10) begin
         step(0, 0, 0, "ball_cool");
         lo++;
      end
      chk("ball_lowcyc", 32'(lo), 32'd2);

      // tracer drain, reject on empty, tracer reload
      apply_reset("t3rst");
      for (int i = 0; i < 8; i++) send(3, i, "tracer");
      chk("t3_tracer", 32'(bus.tracer_count), 32'd0);
      chk("t3_energy", 32'(bus.energy_level), 32'd8);
      step(1, 3, 0, "t3_rej");
      chk("t3_rejpulse", 32'(bus.cmd_reject), 32'd1);
      chk("t3_nofire",   32'(bus.fire_valid), 32'd0);
      send(6, 0, "t3_reload");
      chk("t3_tracer8", 32'(bus.tracer_count), 32'd8);
      chk("t3_energy6", 32'(bus.energy_level), 32'd6);

      // fluid drain, reject, fluid reload
      apply_reset("t4rst");
      for (int i = 0; i < 4; i++) send(4, 3, "impact");
      chk("t4_fempty", 32'(bus.fluid_empty), 32'd1);
      chk("t4_energy", 32'(bus.energy_level), 32'd16);
      step(1, 1, 0, "t4_rej");
      chk("t4_rejpulse", 32'(bus.cmd_reject), 32'd1);
      send(5, 0, "t4_reload");
      chk("t4_fluid", 32'(bus.fluid_level), 32'd64);
      chk("t4_energy14", 32'(bus.energy_level), 32'd14);

      // energy exhaustion into DEAD
      apply_reset("t5rst");
      for (int i = 0; i < 31; i++) send(7, i % 16, "ping");
      step(1, 7, 5, "ping_last");
      chk("t5_eempty", 32'(bus.energy_empty), 32'd1);
      for (int i = 0; i < 22; i++) step(1, 1, 0, "dead");
      chk("t5_dead_ready", 32'(bus.cmd_ready), 32'd0);

      // reset in the middle of a reload
      apply_reset("t6rst");
      send(1, 0, "t6_line");
      send(1, 0, "t6_line");
      chk("t6_fluid56", 32'(bus.fluid_level), 32'd56);
      step(1, 5, 0, "t6_reload");
      step(0, 0, 0, "t6_reload");
      apply_reset("t6_midrst");
      chk("t6_fluid", 32'(bus.fluid_level), 32'd64);
      chk("t6_energy", 32'(bus.energy_level), 32'd32);
      chk("t6_busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, "t6_after");

      // random traffic in short episodes
      for (int ep = 0; ep < 25; ep++) begin
         apply_reset("rnd_rst");
         for (int c = 0; c < 80; c++)
            step(($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 15)), "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
